// File: rtl/conv2_feeder_pkg.sv
// Shared network constants for the conv2 stage and the feeder's state encoding.
package conv2_feeder_pkg;

    localparam int FMAP_WIDTH  = 13;
    localparam int FMAP_HEIGHT = 13;
    localparam int FMAP_CH     = 8;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HOLD   = 2'd1,
        STREAM = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/conv2_fmap_ram.sv
// Feature-map storage: one synchronous write port and one registered read port.
// A read cycle without rd_en returns zero, so the read register doubles as the streamed pixel.
module conv2_fmap_ram #(
    parameter int DEPTH = 169,
    parameter int CH    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CH-1:0] wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    output logic [CH-1:0] rdata
);

    logic [CH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= rd_en ? mem[raddr] : '0;
    end

endmodule

// File: rtl/conv2_feeder.sv
// Buffers one full binary feature map, then streams it in raster order on start.
module conv2_feeder
    import conv2_feeder_pkg::*;
#(
    parameter int WIDTH  = FMAP_WIDTH,
    parameter int HEIGHT = FMAP_HEIGHT,
    parameter int CH     = FMAP_CH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [CH-1:0] wr_data,
    output logic          wr_ready,
    input  logic          start,
    output logic [CH-1:0] pixel_out,
    output logic          valid_out,
    output logic          frame_done,
    output logic          frame_ready
);

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    feeder_state_t state, state_next;
    logic [AW-1:0] wr_cnt, wr_cnt_next;
    logic [AW-1:0] rd_cnt, rd_cnt_next;
    logic [AW-1:0] raddr;
    logic          we;
    logic          rd_en;

    // rd_cnt is the address currently on pixel_out; raddr looks one ahead into the RAM
    always_comb begin
        state_next  = state;
        wr_cnt_next = wr_cnt;
        rd_cnt_next = rd_cnt;
        we          = 1'b0;
        rd_en       = 1'b0;
        raddr       = '0;
        wr_ready    = 1'b0;
        frame_ready = 1'b0;
        case (state)
            FILL: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    we = 1'b1;
                    if (wr_cnt == LAST) begin
                        state_next  = HOLD;
                        wr_cnt_next = '0;
                    end else begin
                        wr_cnt_next = wr_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                frame_ready = 1'b1;
                if (start) begin
                    state_next  = STREAM;
                    rd_en       = 1'b1;
                    rd_cnt_next = '0;
                end
            end
            STREAM: begin
                if (rd_cnt == LAST) begin
                    state_next  = FILL;
                    rd_cnt_next = '0;
                end else begin
                    rd_en       = 1'b1;
                    raddr       = rd_cnt + 1'b1;
                    rd_cnt_next = rd_cnt + 1'b1;
                end
            end
            default: state_next = FILL;
        endcase
        if (rst) begin
            we    = 1'b0;
            rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            wr_cnt     <= wr_cnt_next;
            rd_cnt     <= rd_cnt_next;
            valid_out  <= rd_en;
            frame_done <= rd_en && (raddr == LAST);
        end
    end

    conv2_fmap_ram #(
        .DEPTH(DEPTH),
        .CH   (CH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(wr_cnt),
        .wdata(wr_data),
        .rd_en(rd_en),
        .raddr(raddr),
        .rdata(pixel_out)
    );

endmodule

// File: doc/conv2_feeder.md
CONV2_FEEDER -- requirements
Module: conv2_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 13, giving the feature-map columns.
REQ-002 The block SHALL have parameter HEIGHT, default 13, giving the feature-map rows.
REQ-003 The block SHALL have parameter CH, default 8, giving the binary channels per pixel.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port wr_valid, input, 1 bit: wr_data carries one pixel to store.
REQ-007 Port wr_data, input, CH bits: one pixel, with bit k as channel k+1.
REQ-008 Port wr_ready, output, 1 bit: the block accepts a pixel on this cycle.
REQ-009 Port start, input, 1 bit: request to stream the stored frame.
REQ-010 Port pixel_out, output, CH bits: streamed pixel, with bit k driving downstream pixel_in_(k+1).
REQ-011 Port valid_out, output, 1 bit: pixel_out is valid.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse aligned with the last streamed pixel.
REQ-013 Port frame_ready, output, 1 bit: a full frame is stored and waiting for start.

Function
REQ-014 The block SHALL implement the states FILL, HOLD and STREAM.
REQ-015 FILL: wr_ready SHALL be 1, and each cycle with wr_valid=1 SHALL store wr_data at raster address wr_cnt and increment wr_cnt.
REQ-016 The write on which wr_cnt = WIDTH*HEIGHT-1 (168 at default) SHALL move the state to HOLD on the next cycle and clear wr_cnt.
REQ-017 HOLD: wr_ready SHALL be 0 and frame_ready SHALL be 1.
REQ-018 HOLD with start=1 SHALL move the state to STREAM.
REQ-019 start SHALL be ignored in FILL and STREAM, including a start asserted on the same cycle as the final write.
REQ-020 STREAM: pixel_out and valid_out SHALL be registered.
REQ-021 The first pixel (address 0) SHALL appear with valid_out=1 on the cycle after start is sampled in HOLD, giving a latency of 1 cycle.
REQ-022 STREAM SHALL output one pixel per clock in raster order (row-major, column fastest), with no gaps and no backpressure.
REQ-023 valid_out SHALL be high for exactly WIDTH*HEIGHT consecutive cycles per frame.
REQ-024 frame_done SHALL be 1 only on the cycle carrying address WIDTH*HEIGHT-1.
REQ-025 The cycle after the last pixel, the state SHALL be FILL, with valid_out=0, wr_ready=1 and rd_cnt=0.
REQ-026 Whenever valid_out=0, pixel_out SHALL be all zeros.
REQ-027 wr_ready SHALL be 0 throughout HOLD and STREAM, and wr_valid SHALL be ignored in those states.
REQ-028 wr_cnt and rd_cnt SHALL be $clog2(WIDTH*HEIGHT) bits wide; they SHALL never exceed WIDTH*HEIGHT-1 and SHALL wrap to 0 only through the state transitions above.
REQ-029 Storage SHALL be a WIDTH*HEIGHT x CH register array with one write port and one read port.

Reset
REQ-030 rst=1 SHALL, on the next edge, force state FILL, wr_cnt=0 and rd_cnt=0.
REQ-031 rst=1 SHALL, on the next edge, force pixel_out=0, valid_out=0, frame_done=0 and frame_ready=0, with wr_ready=1 once rst deasserts.
REQ-032 Reset SHALL NOT clear the storage array.
REQ-033 Reset asserted mid-STREAM or mid-FILL SHALL abort the frame with no further valid_out until a new full fill and start.

Structure
REQ-034 The shared network package SHALL hold the feature-map constants (13, 13, 8) and the feeder state enum.
REQ-035 One sub-module SHALL be used: conv2_fmap_ram (the synchronous-write, registered-read storage array); the control FSM stays in the top module.

Verification
REQ-036 Fill 169 pixels with wr_data=address[7:0], then pulse start: valid_out rises 1 cycle later, pixel_out runs 0..168, valid_out is high exactly 169 cycles, and frame_done coincides with pixel_out=168.
REQ-037 Fill with wr_valid toggling every other cycle: HOLD is entered only after the 169th accepted write, frame_ready=1, and wr_ready=0 afterwards.
REQ-038 Assert start during FILL and on the cycle of the final write: no streaming occurs; a later start in HOLD streams normally.
REQ-039 Assert rst at stream pixel 50: the next cycle has valid_out=0, pixel_out=0 and wr_ready=1; a refill with 0xA5 then start streams 169 pixels of 0xA5.
REQ-040 Run two back-to-back frames (data 0xFF, then 0x00): the second fill starts the cycle after the first frame_done, and no stale data or extra valid cycles appear.
